ahb_bus_arbiter: RTL and testbench
==================================

Name: ahb_bus_arbiter

Overview:
- Two-master AHB arbiter and multiplexer in front of the system address decoder.
- m0 is the PicoRV32 bridge; m1 is the DMA or debug master.
- Grants one master the shared AHB address phase and tracks the data-phase owner so write data is steered correctly.
- Its shared haddr/htrans/hwrite/hsize/hwdata outputs feed the RAM/PIO/APB decode and the slaves.

Parameters:
- PRIORITY_MODE, 0: 0 = fixed priority with m0 highest; 1 = round-robin.
- DEFAULT_MASTER, 0: master parked on the grant when nobody requests.
- MAX_HOLD, 16: consecutive owner cycles allowed while the other master waits, range 1..255.

Ports:
- hclk  in  1  system clock
- hreset  in  1  asynchronous reset, active-high
- m0_hbusreq  in  1  m0 bus request
- m0_hgrant  out  1  m0 owns the next address phase
- m0_htrans  in  2  m0 transfer type
- m0_haddr  in  32  m0 address
- m0_hwrite  in  1  m0 write
- m0_hsize  in  3  m0 size
- m0_hwdata  in  32  m0 write data
- m1_hbusreq, m1_hgrant, m1_htrans, m1_haddr, m1_hwrite, m1_hsize, m1_hwdata: same widths and meanings as m0
- haddr  out  32  shared address
- htrans  out  2  shared transfer type
- hwrite  out  1  shared write
- hsize  out  3  shared size
- hwdata  out  32  data-phase owner's write data
- hmaster  out  1  address-phase owner index
- hmaster_data  out  1  data-phase owner index
- hready  in  1  slave-mux ready, also broadcast to both masters externally

Behaviour:
- Reset, asynchronous: owner = DEFAULT_MASTER, hmaster_data = DEFAULT_MASTER, hold counter = 0, rr pointer = 0. hgrant of DEFAULT_MASTER = 1, the other = 0.
- Reset forces shared htrans to IDLE (2'b00) for the cycle immediately after reset release, whatever the masters drive.
- Address mux, combinational from the owner register: haddr/htrans/hwrite/hsize = owner's signals; hmaster = owner.
- Data mux: hwdata = hwdata of hmaster_data.
- On each hclk edge with hready=1: hmaster_data <= owner.
- When hready=0: owner, hmaster_data, counter and rr pointer all hold. No handover ever occurs during a wait state.
- Arbitration is evaluated only on edges with hready=1. A switch is permitted only if the owner's htrans != SEQ (2'b11), so bursts are never split.
- Candidate selection:
  - Fixed mode: m0 if m0_hbusreq, else m1 if m1_hbusreq.
  - Round-robin mode: the requester other than the last granted one is preferred.
  - No requests: DEFAULT_MASTER.
- Handover rule: if the current owner still requests and the other waits, switch only when hold counter >= MAX_HOLD-1 (fixed mode included) or the owner deasserts hbusreq. Otherwise switch to the candidate.
- Grant timing: hgrant outputs are registered, equal to (owner == x), and change on the same edge as owner. The new owner's first address phase is the cycle after the switching edge.
- Hold counter:
  - Increments on each hready=1 edge while the owner is unchanged and the other master requests.
  - Clears on any switch or when the other master does not request.
  - Saturates at 255.
- Switch in a SEQ cycle with the counter expired: the switch is deferred to the first hready=1 edge where the owner's htrans != SEQ.
- Both requesting at reset release: the fixed/rr rule applies on the first hready=1 edge.

Optional Feature:
- Macro AHB_ARB_LOCK_EN.
- With it defined:
  - Adds inputs m0_hlock and m1_hlock, 1 bit each.
  - While the owner's hlock=1, no handover occurs and the hold counter is frozen at 0.
  - Adds output hmastlock, 1 bit, = owner's hlock.
- Without it: no lock ports; arbitration uses only hbusreq, SEQ protection and MAX_HOLD.

Test Plan:
- Reset with hreset=1 mid-burst from m1 -> m0_hgrant=1, m1_hgrant=0, hmaster=0, hmaster_data=0 immediately; htrans=IDLE the first cycle after release.
- PRIORITY_MODE=0, both hbusreq=1 from idle, m0 NONSEQ singles -> m0 holds the grant; at cycle MAX_HOLD=16 the grant moves to m1 (m1_hgrant=1, hmaster=1).
- PRIORITY_MODE=1, both requesting singles, MAX_HOLD=1 -> hmaster alternates 0,1,0,1 on consecutive hready=1 edges.
- m0 INCR4 burst (NONSEQ,SEQ,SEQ,SEQ) with counter expired at the 2nd beat -> owner switches only after the 4th beat; the m1 NONSEQ appears on haddr on the next cycle.
- m0 write to 0x10000004, then handover to m1 read; hready=0 for 2 cycles in the m0 data phase -> hwdata = m0_hwdata and hmaster_data=0 until hready=1; m1 address held until then.
- With AHB_ARB_LOCK_EN, m0_hlock=1 for 40 cycles with m1 requesting -> no handover and hmastlock=1; the grant moves to m1 the edge after m0_hlock drops (non-SEQ).

Source files
------------

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB arbiter and address/data multiplexer with burst protection and a hold limit.
// Define AHB_ARB_LOCK_EN to add m0_hlock/m1_hlock inputs and the hmastlock output.
module ahb_bus_arbiter #(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        m0_hbusreq,
    output logic        m0_hgrant,
    input  logic [1:0]  m0_htrans,
    input  logic [31:0] m0_haddr,
    input  logic        m0_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [31:0] m0_hwdata,
    input  logic        m1_hbusreq,
    output logic        m1_hgrant,
    input  logic [1:0]  m1_htrans,
    input  logic [31:0] m1_haddr,
    input  logic        m1_hwrite,
    input  logic [2:0]  m1_hsize,
    input  logic [31:0] m1_hwdata,
`ifdef AHB_ARB_LOCK_EN
    input  logic        m0_hlock,
    input  logic        m1_hlock,
    output logic        hmastlock,
`endif
    output logic [31:0] haddr,
    output logic [1:0]  htrans,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [31:0] hwdata,
    output logic        hmaster,
    output logic        hmaster_data,
    input  logic        hready
);

    localparam logic       DEF_M       = (DEFAULT_MASTER != 0) ? 1'b1 : 1'b0;
    localparam logic       RR_MODE     = (PRIORITY_MODE != 0) ? 1'b1 : 1'b0;
    localparam logic [8:0] HOLD_MAX    = 9'(MAX_HOLD);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    logic       owner_r;
    logic       hmaster_data_r;
    logic       rr_last_r;
    logic       parked_r;
    logic       post_rst_r;
    logic       m0_hgrant_r;
    logic       m1_hgrant_r;
    logic [7:0] hold_cnt_r;

    logic       owner_req_s;
    logic       other_req_s;
    logic       owner_lock_s;
    logic [1:0] owner_htrans_s;
    logic       hold_expired_s;
    logic       cand_s;
    logic       want_s;
    logic       next_owner_s;
    logic       next_req_s;

`ifdef AHB_ARB_LOCK_EN
    assign owner_lock_s = owner_r ? m1_hlock : m0_hlock;
    assign hmastlock    = owner_lock_s;
`else
    assign owner_lock_s = 1'b0;
`endif

    assign m0_hgrant      = m0_hgrant_r;
    assign m1_hgrant      = m1_hgrant_r;
    assign hmaster        = owner_r;
    assign hmaster_data   = hmaster_data_r;
    assign hold_expired_s = (({1'b0, hold_cnt_r} + 9'd1) >= HOLD_MAX);
    assign next_req_s     = next_owner_s ? m1_hbusreq : m0_hbusreq;

    // Address-phase mux driven by the registered owner
    always_comb begin
        if (owner_r) begin
            haddr          = m1_haddr;
            owner_htrans_s = m1_htrans;
            hwrite         = m1_hwrite;
            hsize          = m1_hsize;
            owner_req_s    = m1_hbusreq;
            other_req_s    = m0_hbusreq;
        end else begin
            haddr          = m0_haddr;
            owner_htrans_s = m0_htrans;
            hwrite         = m0_hwrite;
            hsize          = m0_hsize;
            owner_req_s    = m0_hbusreq;
            other_req_s    = m1_hbusreq;
        end
    end

    // Shared htrans, masked to IDLE for the first cycle out of reset
    always_comb begin
        if (post_rst_r) begin
            htrans = HTRANS_IDLE;
        end else begin
            htrans = owner_htrans_s;
        end
    end

    // Data-phase write data follows the data-phase owner
    always_comb begin
        if (hmaster_data_r) begin
            hwdata = m1_hwdata;
        end else begin
            hwdata = m0_hwdata;
        end
    end

    // Candidate selection, hold-limit handover and burst/lock protection
    always_comb begin
        cand_s = DEF_M;
        if (m0_hbusreq && m1_hbusreq) begin
            if (RR_MODE) begin
                cand_s = ~rr_last_r;
            end else begin
                cand_s = 1'b0;
            end
        end else if (m0_hbusreq) begin
            cand_s = 1'b0;
        end else if (m1_hbusreq) begin
            cand_s = 1'b1;
        end else begin
            cand_s = DEF_M;
        end

        // A parked owner never earned the bus, so the plain candidate rule applies to it
        if (!parked_r && owner_req_s && other_req_s) begin
            if (hold_expired_s) begin
                want_s = ~owner_r;
            end else begin
                want_s = owner_r;
            end
        end else begin
            want_s = cand_s;
        end

        if ((htrans != HTRANS_SEQ) && !owner_lock_s) begin
            next_owner_s = want_s;
        end else begin
            next_owner_s = owner_r;
        end
    end

    // Ownership, grants, hold counter and round-robin state; all frozen during wait states
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            owner_r        <= DEF_M;
            hmaster_data_r <= DEF_M;
            rr_last_r      <= 1'b0;
            parked_r       <= 1'b1;
            post_rst_r     <= 1'b1;
            m0_hgrant_r    <= ~DEF_M;
            m1_hgrant_r    <= DEF_M;
            hold_cnt_r     <= 8'd0;
        end else begin
            post_rst_r <= 1'b0;
            if (hready) begin
                owner_r        <= next_owner_s;
                hmaster_data_r <= owner_r;
                m0_hgrant_r    <= ~next_owner_s;
                m1_hgrant_r    <= next_owner_s;
                parked_r       <= ~next_req_s;
                if (next_req_s) begin
                    rr_last_r <= next_owner_s;
                end
                if ((next_owner_s != owner_r) || owner_lock_s || !other_req_s) begin
                    hold_cnt_r <= 8'd0;
                end else if (hold_cnt_r != 8'hFF) begin
                    hold_cnt_r <= hold_cnt_r + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Bench for ahb_bus_arbiter: a fixed-priority (MAX_HOLD=16) and a round-robin (MAX_HOLD=1) instance
// share stimulus; expected values come from hand-derived tables queued as a scoreboard.
module tb_ahb_bus_arbiter;

    localparam logic [1:0]  IDLE = 2'b00;
    localparam logic [1:0]  NSQ  = 2'b10;
    localparam logic [1:0]  SEQ  = 2'b11;
    localparam logic [31:0] M0_ADDR = 32'h1000_0004;
    localparam logic [31:0] M1_ADDR = 32'h2000_0008;
    localparam logic [31:0] M0_WD   = 32'hCAFE_0001;
    localparam logic [31:0] M1_WD   = 32'h5EED_0002;

    logic        hclk;
    logic        hreset;
    logic        hready;
    logic        m0_hbusreq, m1_hbusreq;
    logic [1:0]  m0_htrans, m1_htrans;
    logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata;
    logic        m0_hwrite, m1_hwrite;
    logic [2:0]  m0_hsize, m1_hsize;
    logic        m0_hlock, m1_hlock;

    logic        fx_m0_hgrant, fx_m1_hgrant, fx_hwrite, fx_hmaster, fx_hmaster_data, fx_hmastlock;
    logic [31:0] fx_haddr, fx_hwdata;
    logic [1:0]  fx_htrans;
    logic [2:0]  fx_hsize;
    logic        rr_m0_hgrant, rr_m1_hgrant, rr_hwrite, rr_hmaster, rr_hmaster_data, rr_hmastlock;
    logic [31:0] rr_haddr, rr_hwdata;
    logic [1:0]  rr_htrans;
    logic [2:0]  rr_hsize;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       clr;
        logic       m0_req;
        logic       m1_req;
        logic [1:0] m0_tr;
        logic [1:0] m1_tr;
        logic       rdy;
        logic       exp_m;
        logic       exp_d;
    } vec_t;

    typedef struct {
        logic exp_m;
        logic exp_d;
        logic chk_rr;
        logic exp_rr;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[0:31];
    int   n_tbl = 0;

    ahb_bus_arbiter #(.PRIORITY_MODE(0), .DEFAULT_MASTER(0), .MAX_HOLD(16)) dut_fx (
        .hclk(hclk), .hreset(hreset),
        .m0_hbusreq(m0_hbusreq), .m0_hgrant(fx_m0_hgrant), .m0_htrans(m0_htrans), .m0_haddr(m0_haddr),
        .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hwdata(m0_hwdata),
        .m1_hbusreq(m1_hbusreq), .m1_hgrant(fx_m1_hgrant), .m1_htrans(m1_htrans), .m1_haddr(m1_haddr),
        .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hwdata(m1_hwdata),
`ifdef AHB_ARB_LOCK_EN
        .m0_hlock(m0_hlock), .m1_hlock(m1_hlock), .hmastlock(fx_hmastlock),
`endif
        .haddr(fx_haddr), .htrans(fx_htrans), .hwrite(fx_hwrite), .hsize(fx_hsize), .hwdata(fx_hwdata),
        .hmaster(fx_hmaster), .hmaster_data(fx_hmaster_data), .hready(hready)
    );

    ahb_bus_arbiter #(.PRIORITY_MODE(1), .DEFAULT_MASTER(0), .MAX_HOLD(1)) dut_rr (
        .hclk(hclk), .hreset(hreset),
        .m0_hbusreq(m0_hbusreq), .m0_hgrant(rr_m0_hgrant), .m0_htrans(m0_htrans), .m0_haddr(m0_haddr),
        .m0_hwrite(m0_hwrite), .m0_hsize(m0_hsize), .m0_hwdata(m0_hwdata),
        .m1_hbusreq(m1_hbusreq), .m1_hgrant(rr_m1_hgrant), .m1_htrans(m1_htrans), .m1_haddr(m1_haddr),
        .m1_hwrite(m1_hwrite), .m1_hsize(m1_hsize), .m1_hwdata(m1_hwdata),
`ifdef AHB_ARB_LOCK_EN
        .m0_hlock(m0_hlock), .m1_hlock(m1_hlock), .hmastlock(rr_hmastlock),
`endif
        .haddr(rr_haddr), .htrans(rr_htrans), .hwrite(rr_hwrite), .hsize(rr_hsize), .hwdata(rr_hwdata),
        .hmaster(rr_hmaster), .hmaster_data(rr_hmaster_data), .hready(hready)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic m0r, input logic m1r, input logic [1:0] m0t,
                                input logic [1:0] m1t, input logic rdy, input logic em, input logic ed);
        vec_t v;
        v.clr = clr; v.m0_req = m0r; v.m1_req = m1r; v.m0_tr = m0t; v.m1_tr = m1t;
        v.rdy = rdy; v.exp_m = em; v.exp_d = ed;
        return v;
    endfunction

    task automatic add(input vec_t v);
        tbl[n_tbl] = v;
        n_tbl++;
    endtask

    task automatic do_reset();
        m0_hbusreq = 1'b0; m1_hbusreq = 1'b0; m0_htrans = IDLE; m1_htrans = IDLE;
        m0_hlock = 1'b0; m1_hlock = 1'b0; hready = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b1;
        @(posedge hclk); #4;
        hreset = 1'b0;
    endtask

    // Drive one cycle, queue its expectation, and check the DUT outputs after the edge
    task automatic apply(input vec_t v, input logic chk_rr, input logic exp_rr);
        exp_t e;
        if (v.clr) do_reset();
        m0_hbusreq = v.m0_req; m1_hbusreq = v.m1_req;
        m0_htrans = v.m0_tr;   m1_htrans = v.m1_tr;
        hready = v.rdy;
        e.exp_m = v.exp_m; e.exp_d = v.exp_d; e.chk_rr = chk_rr; e.exp_rr = exp_rr;
        sb_q.push_back(e);
        @(posedge hclk); #1;
        e = sb_q.pop_front();
        chk1("fx_hmaster", fx_hmaster, e.exp_m);
        chk1("fx_m0_hgrant", fx_m0_hgrant, ~e.exp_m);
        chk1("fx_m1_hgrant", fx_m1_hgrant, e.exp_m);
        chk1("fx_hmaster_data", fx_hmaster_data, e.exp_d);
        chk32("fx_haddr", fx_haddr, e.exp_m ? M1_ADDR : M0_ADDR);
        chk32("fx_htrans", 32'(fx_htrans), 32'(e.exp_m ? v.m1_tr : v.m0_tr));
        chk1("fx_hwrite", fx_hwrite, ~e.exp_m);
        chk32("fx_hsize", 32'(fx_hsize), e.exp_m ? 32'd0 : 32'd2);
        chk32("fx_hwdata", fx_hwdata, e.exp_d ? M1_WD : M0_WD);
        if (e.chk_rr) begin
            chk1("rr_hmaster", rr_hmaster, e.exp_rr);
            chk1("rr_m1_hgrant", rr_m1_hgrant, e.exp_rr);
            chk1("rr_m0_hgrant", rr_m0_hgrant, ~e.exp_rr);
            chk32("rr_haddr", rr_haddr, e.exp_rr ? M1_ADDR : M0_ADDR);
            chk1("rr_hwrite", rr_hwrite, ~e.exp_rr);
        end
    endtask

    initial begin
        hreset = 1'b1; hready = 1'b1;
        m0_hbusreq = 1'b0; m1_hbusreq = 1'b0; m0_htrans = IDLE; m1_htrans = IDLE;
        m0_hlock = 1'b0; m1_hlock = 1'b0;
        m0_haddr = M0_ADDR; m1_haddr = M1_ADDR; m0_hwdata = M0_WD; m1_hwdata = M1_WD;
        m0_hwrite = 1'b1; m1_hwrite = 1'b0; m0_hsize = 3'b010; m1_hsize = 3'b000;

        // INCR4 from m0 with the hold limit expiring on beat 2: switch waits for the non-SEQ edge 19
        for (int k = 1; k <= 19; k++) begin
            add(mk(k == 1, 1'b1, 1'b1, (k >= 16 && k <= 18) ? SEQ : NSQ, NSQ, 1'b1, k >= 19, 1'b0));
        end
        // m0 write then handover to m1 read, two wait states in the m0 data phase, then parking
        add(mk(1'b1, 1'b1, 1'b0, NSQ,  IDLE, 1'b1, 1'b0, 1'b0));
        add(mk(1'b0, 1'b0, 1'b1, NSQ,  NSQ,  1'b1, 1'b1, 1'b0));
        add(mk(1'b0, 1'b0, 1'b1, IDLE, NSQ,  1'b0, 1'b1, 1'b0));
        add(mk(1'b0, 1'b0, 1'b1, IDLE, NSQ,  1'b0, 1'b1, 1'b0));
        add(mk(1'b0, 1'b0, 1'b1, IDLE, NSQ,  1'b1, 1'b1, 1'b1));
        add(mk(1'b0, 1'b0, 1'b0, IDLE, IDLE, 1'b1, 1'b0, 1'b1));

        // m1 takes the bus and starts a burst, then reset hits mid-burst
        do_reset();
        apply(mk(1'b0, 1'b0, 1'b1, IDLE, NSQ, 1'b1, 1'b1, 1'b0), 1'b1, 1'b1);
        apply(mk(1'b0, 1'b0, 1'b1, IDLE, SEQ, 1'b1, 1'b1, 1'b1), 1'b1, 1'b1);
        m0_hbusreq = 1'b1; m0_htrans = NSQ;
        #2 hreset = 1'b1;
        #1;
        chk1("rst_m0_hgrant", fx_m0_hgrant, 1'b1);
        chk1("rst_m1_hgrant", fx_m1_hgrant, 1'b0);
        chk1("rst_hmaster", fx_hmaster, 1'b0);
        chk1("rst_hmaster_data", fx_hmaster_data, 1'b0);
        chk1("rst_rr_hmaster", rr_hmaster, 1'b0);
        chk32("rst_htrans", 32'(fx_htrans), 32'd0);
        @(negedge hclk);
        hreset = 1'b0;
        #1;
        chk32("post_rst_htrans", 32'(fx_htrans), 32'd0);
        @(posedge hclk); #1;
        chk32("first_edge_htrans", 32'(fx_htrans), 32'(NSQ));
        chk1("first_edge_fx_hmaster", fx_hmaster, 1'b0);
        chk1("first_edge_rr_hmaster", rr_hmaster, 1'b1);

        // Both request singles: fixed hands over on edge 16, round-robin alternates every edge
        for (int k = 1; k <= 20; k++) begin
            apply(mk(k == 1, 1'b1, 1'b1, NSQ, NSQ, 1'b1, k >= 16, k >= 17), 1'b1, (k % 2) == 1);
        end

        for (int i = 0; i < n_tbl; i++) begin
            apply(tbl[i], 1'b0, 1'b0);
        end

`ifdef AHB_ARB_LOCK_EN
        // Locked m0 keeps the bus well past MAX_HOLD; releasing lock and request hands over at once
        do_reset();
        m0_hlock = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            apply(mk(1'b0, 1'b1, 1'b1, NSQ, NSQ, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
            chk1("hmastlock_held", fx_hmastlock, 1'b1);
        end
        m0_hlock = 1'b0;
        apply(mk(1'b0, 1'b0, 1'b1, IDLE, NSQ, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
        chk1("hmastlock_released", fx_hmastlock, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
